// File: rtl/matmul_arbiter.sv
// matmul_arbiter
//   Round-robin arbiter that lets NUM_REQ requesters share one 16x16
//   multiplier, with a watchdog that abandons a hung job and flushes.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req         per-requester level request, held until its job_done
//   grant       one-hot owner of the multiplier, zero when no job is active
//   sel         binary index of the owner (operand/result mux select)
//   busy        high whenever the arbiter is not IDLE
//   job_done    one-cycle pulse on the owner's bit, result valid that cycle
//   timeout     one-cycle pulse when the watchdog fires
//   timeout_id  owner index of the last timed-out job
//   mm_start    level start to the multiplier
//   mm_done     level done from the multiplier
module matmul_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 96,
    parameter int FLUSH_CYCLES   = 64,
    localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [SW-1:0]      sel,
    output logic               busy,
    output logic [NUM_REQ-1:0] job_done,
    output logic               timeout,
    output logic [SW-1:0]      timeout_id,
    output logic               mm_start,
    input  logic               mm_done
);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE, FLUSH} state_t;

    state_t        state, state_d;
    logic [SW-1:0] rr_ptr;
    logic [7:0]    wdog;
    logic [7:0]    flush_cnt;

    logic          grant_evt, done_evt, to_evt;
    logic          found;
    logic [SW-1:0] winner;
    logic [SW:0]   idx;

    assign busy     = (state != IDLE);
    assign mm_start = (state == BUSY);

    // First set request at or above rr_ptr, wrapping past NUM_REQ-1 to 0.
    // idx carries one spare bit so the wrap can be detected before reducing.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, rr_ptr} + (SW+1)'(i);
            if (idx >= (SW+1)'(NUM_REQ))
                idx = idx - (SW+1)'(NUM_REQ);
            if (!found && req[idx[SW-1:0]]) begin
                found  = 1'b1;
                winner = idx[SW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state;
        grant_evt = 1'b0;
        done_evt  = 1'b0;
        to_evt    = 1'b0;
        case (state)
            IDLE: if (found) begin
                state_d   = BUSY;
                grant_evt = 1'b1;
            end
            // mm_done is tested first so a completion on the watchdog's
            // last cycle still counts as a finished job.
            BUSY: if (mm_done) begin
                state_d  = RELEASE;
                done_evt = 1'b1;
            end else if (wdog == 8'(TIMEOUT_CYCLES-1)) begin
                state_d = FLUSH;
                to_evt  = 1'b1;
            end
            // Wait for the multiplier to drop done before the next job.
            RELEASE: if (!mm_done) state_d = IDLE;
            FLUSH:   if (flush_cnt == 8'(FLUSH_CYCLES-1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant      <= '0;
            sel        <= '0;
            job_done   <= '0;
            timeout    <= 1'b0;
            timeout_id <= '0;
            wdog       <= '0;
            flush_cnt  <= '0;
        end else begin
            state    <= state_d;
            job_done <= '0;
            timeout  <= 1'b0;
            if (state == BUSY)  wdog      <= wdog + 8'd1;
            if (state == FLUSH) flush_cnt <= flush_cnt + 8'd1;
            if (grant_evt) begin
                grant  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
                sel    <= winner;
                rr_ptr <= (winner == SW'(NUM_REQ-1)) ? '0 : winner + SW'(1);
                wdog   <= '0;
            end
            if (done_evt) job_done <= grant;
            if (to_evt) begin
                timeout    <= 1'b1;
                timeout_id <= sel;
                flush_cnt  <= '0;
            end
            if (state != IDLE && state_d == IDLE) begin
                grant <= '0;
                sel   <= '0;
            end
        end
    end

endmodule

// File: doc/matmul_arbiter.md
MATMUL_ARBITER -- requirements
Module: matmul_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one 16x16 multiplier; legal range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 96, maximum cycles in BUSY before the watchdog fires; legal range 60..255.
REQ-003 Parameter FLUSH_CYCLES, default 64, cycles spent in FLUSH after a timeout; legal range 1..255.
REQ-004 Reset rst_n, asynchronous, active-low; clock clk.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req  input  NUM_REQ  per-requester level request; held high until that requester's done pulse.
REQ-008 grant  output  NUM_REQ  one-hot owner of the multiplier; all-zero when no job is active.
REQ-009 sel  output  SW=max(1,clog2(NUM_REQ))  binary index of the granted requester, for the operand and result mux.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 job_done  output  NUM_REQ  one-cycle pulse on the owner's bit; matrix_c is valid in that cycle.
REQ-012 timeout  output  1  one-cycle pulse when the watchdog fires.
REQ-013 timeout_id  output  SW  index of the timed-out owner; held until the next timeout or reset.
REQ-014 mm_start  output  1  level start to the multiplier.
REQ-015 mm_done  input  1  level done from the multiplier.

Function
REQ-016 The block SHALL implement four states: IDLE, BUSY, RELEASE and FLUSH.
REQ-017 IDLE with req != 0 at an edge: the next cycle SHALL be BUSY with grant, sel and busy valid and mm_start=1.
REQ-018 The winner SHALL be the first set req bit at or above rr_ptr, searching upward with wrap from NUM_REQ-1 to 0.
REQ-019 rr_ptr SHALL reset to 0 and be set to (winner+1) mod NUM_REQ when the grant is issued.
REQ-020 In BUSY, mm_start SHALL stay 1 and grant/sel SHALL stay constant until mm_done=1 is sampled or the watchdog fires.
REQ-021 BUSY with mm_done=1 sampled: the next cycle SHALL be RELEASE with mm_start=0 and job_done[owner]=1 for exactly that cycle.
REQ-022 In RELEASE, grant and sel SHALL be held; the block SHALL return to IDLE on the first edge at which mm_done=0, with a minimum RELEASE duration of 1 cycle.
REQ-023 grant SHALL clear on entry to IDLE.
REQ-024 A new grant SHALL NOT issue earlier than the cycle after IDLE is entered, so there is at least one cycle of mm_start=0 between jobs.
REQ-025 The watchdog counter SHALL be 8-bit, clear on BUSY entry and increment each BUSY cycle.
REQ-026 If the watchdog count reaches TIMEOUT_CYCLES-1 without mm_done, the next cycle SHALL be FLUSH with mm_start=0, timeout=1 and timeout_id=owner, and no job_done for that owner.
REQ-027 When mm_done and the watchdog limit occur in the same cycle, mm_done SHALL win and the normal job_done path SHALL be taken.
REQ-028 FLUSH SHALL last exactly FLUSH_CYCLES cycles with grant held, then return to IDLE.
REQ-029 mm_done SHALL be ignored in IDLE and FLUSH.
REQ-030 A requester dropping req mid-job SHALL NOT abort the job; job_done SHALL still pulse for that requester.
REQ-031 New or changed requests arriving outside IDLE SHALL be evaluated only on the next IDLE cycle.
REQ-032 At most one grant bit and at most one job_done bit SHALL be set in any cycle.

Reset
REQ-033 While rst_n=0, the block SHALL hold state=IDLE and rr_ptr=0.
REQ-034 While rst_n=0, the block SHALL hold grant=0, sel=0, busy=0, job_done=0, timeout=0, timeout_id=0, mm_start=0 and watchdog=0.
REQ-035 Reset mid-job SHALL abort immediately without a job_done pulse.
REQ-036 After reset release, the first IDLE cycle SHALL arbitrate normally from rr_ptr=0.

Verification
REQ-037 Single job: req=0001, mm_done model rises 51 cycles after mm_start -> grant=0001 and sel=0 for the whole job; job_done=0001 for 1 cycle; mm_start falls the same cycle; busy returns to 0 after mm_done falls.
REQ-038 Round-robin: req=1111 held and each completed requester drops its req after job_done -> grant order 0001, 0010, 0100, 1000; then re-raising req=1111 grants 0001 again.
REQ-039 Pointer wrap: after a job for requester 2, req=0011 -> grant=0001; req drop mid-job -> job still completes and job_done[bit] pulses.
REQ-040 Timeout: mm_done tied 0, TIMEOUT_CYCLES=96 -> timeout pulse on the 97th cycle after mm_start rose, timeout_id=owner, mm_start=0, no job_done; busy stays high for 64 cycles then falls.
REQ-041 Reset and spurious done: rst_n pulsed low mid-BUSY -> all outputs 0 immediately and rr_ptr=0; mm_done=1 in IDLE with req=0 -> no state change.
